// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg
// Shared definitions for the shadow register scoreboard.
//   REG_ADDR_W / NUM_REGS : register-index width and architectural register count
//   stage_tag_t           : per-stage tag {wb_en, mem_read, dest}
//   BUBBLE                : all-zero tag loaded when a stage carries no instruction
//   tag_match()           : "stage s will write register src"
package arm_pipe_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] dest;
    } stage_tag_t;

    localparam stage_tag_t BUBBLE = '{wb_en: 1'b0, mem_read: 1'b0, dest: '0};

    function automatic logic tag_match(input stage_tag_t s, input logic [REG_ADDR_W-1:0] src);
        return s.wb_en && (s.dest == src);
    endfunction

endpackage

// File: rtl/register_scoreboard_stage_reg.sv
// scoreboard_stage_reg
// One shadow pipeline stage: a tag register with asynchronous reset to BUBBLE,
// a hold enable and a bubble-load override.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   en_i     : 1 = advance this edge, 0 = hold (cache-miss freeze)
//   bubble_i : when advancing, load BUBBLE instead of tag_d_i
//   tag_d_i  : tag coming from the previous stage
//   tag_q_o  : current stage contents
module scoreboard_stage_reg
    import arm_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       bubble_i,
    input  stage_tag_t tag_d_i,
    output stage_tag_t tag_q_o
);

    stage_tag_t tag_q;
    stage_tag_t tag_d;

    always_comb begin
        tag_d = tag_q;
        if (en_i) begin
            tag_d = bubble_i ? BUBBLE : tag_d_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= BUBBLE;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_q_o = tag_q;

endmodule

// File: rtl/register_scoreboard.sv
// register_scoreboard
// Tracks destination registers of in-flight instructions in a shadow EX/MEM/WB
// pipeline, exports the MEM/WB write-back tags for forwarding, and produces the
// ID-stage hazard stall.
//   clk, rst                : clock, asynchronous active-high reset
//   freeze                  : cache-miss freeze, all shadow stages hold
//   flush                   : taken branch, the ID instruction is not issued
//   id_valid .. id_dest     : decoded ID-stage instruction
//   hazard_stall            : combinational stall for PC / IF-ID, bubble into EX
//   wb_mem, reg_dest_mem    : MEM-stage write enable / destination
//   wb_wb, reg_dest_wb      : WB-stage write enable / destination
//   pending_mask            : bit r set when some in-flight stage will write r
//   stall_count             : saturating count of counted stall cycles
//
// Issue handshake: the ID instruction is taken into EX on a rising edge when
// id_valid && !hazard_stall && !flush && !freeze; hazard_stall acts as the
// inverted ready. With freeze=1 nothing moves regardless of the other inputs.
module register_scoreboard
    import arm_pipe_pkg::stage_tag_t;
    import arm_pipe_pkg::tag_match;
#(
    // Stage tags are built from arm_pipe_pkg, so REG_ADDR_W must equal the
    // package value.
    parameter int REG_ADDR_W = arm_pipe_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = arm_pipe_pkg::NUM_REGS,
    parameter bit FWD_EN     = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src_1,
    input  logic [REG_ADDR_W-1:0] id_src_2,
    input  logic                  id_two_src,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    output logic                  hazard_stall,
    output logic                  wb_mem,
    output logic [REG_ADDR_W-1:0] reg_dest_mem,
    output logic                  wb_wb,
    output logic [REG_ADDR_W-1:0] reg_dest_wb,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [CNT_W-1:0]      stall_count
);

    stage_tag_t ex_q;
    stage_tag_t mem_q;
    stage_tag_t wb_q;
    stage_tag_t id_tag;

    logic hit_ex;
    logic hit_mem;
    logic stall_raw;
    logic issue;
    logic advance;

    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    assign id_tag  = '{wb_en: id_wb_en, mem_read: id_mem_read, dest: id_dest};
    assign advance = !freeze;

    // src_2 only counts when the instruction actually reads it.
    assign hit_ex  = tag_match(ex_q, id_src_1)  || (id_two_src && tag_match(ex_q, id_src_2));
    assign hit_mem = tag_match(mem_q, id_src_1) || (id_two_src && tag_match(mem_q, id_src_2));

    // With forwarding only a load in EX cannot be bypassed in time. WB never
    // stalls because the register file writes on the falling edge.
    assign stall_raw    = FWD_EN ? (ex_q.mem_read && hit_ex) : (hit_ex || hit_mem);
    assign hazard_stall = id_valid && !flush && stall_raw;
    assign issue        = id_valid && !flush && !hazard_stall;

    scoreboard_stage_reg u_ex (
        .clk      (clk),
        .rst      (rst),
        .en_i     (advance),
        .bubble_i (!issue),
        .tag_d_i  (id_tag),
        .tag_q_o  (ex_q)
    );

    scoreboard_stage_reg u_mem (
        .clk      (clk),
        .rst      (rst),
        .en_i     (advance),
        .bubble_i (1'b0),
        .tag_d_i  (ex_q),
        .tag_q_o  (mem_q)
    );

    scoreboard_stage_reg u_wb (
        .clk      (clk),
        .rst      (rst),
        .en_i     (advance),
        .bubble_i (1'b0),
        .tag_d_i  (mem_q),
        .tag_q_o  (wb_q)
    );

    // Duplicated destinations collapse into a single bit by construction.
    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((ex_q.wb_en  && (ex_q.dest  == r[REG_ADDR_W-1:0])) ||
                (mem_q.wb_en && (mem_q.dest == r[REG_ADDR_W-1:0])) ||
                (wb_q.wb_en  && (wb_q.dest  == r[REG_ADDR_W-1:0]))) begin
                pending_mask[r] = 1'b1;
            end
        end
    end

    // Only unfrozen stall cycles are counted; the counter sticks at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard_stall && advance && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign wb_mem       = mem_q.wb_en;
    assign reg_dest_mem = mem_q.dest;
    assign wb_wb        = wb_q.wb_en;
    assign reg_dest_wb  = wb_q.dest;
    assign stall_count  = stall_count_q;

    // mem_read is only consulted in EX.
    logic unused_mem_read;
    assign unused_mem_read = mem_q.mem_read ^ wb_q.mem_read;

endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard
// Directed bench. u_dut_a: FWD_EN=1, CNT_W=16. u_dut_b: FWD_EN=0, CNT_W=4 so
// counter saturation is reachable in a few dozen cycles. WB tags of u_dut_a are
// checked by a monitor against a queue filled when instructions are issued.
module tb_register_scoreboard;

    typedef struct packed {
        logic       valid;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic       wb;
        logic       mr;
        logic [3:0] dest;
    } id_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    id_t  id_a = '0;
    id_t  id_b = '0;
    id_t  nop  = '0;
    logic freeze_a = 1'b0;
    logic flush_a  = 1'b0;
    logic freeze_b = 1'b0;
    logic flush_b  = 1'b0;

    logic        hz_a, wb_mem_a, wb_wb_a;
    logic [3:0]  rdm_a, rdw_a;
    logic [15:0] pm_a;
    logic [15:0] cnt_a;

    logic        hz_b, wb_mem_b, wb_wb_b;
    logic [3:0]  rdm_b, rdw_b;
    logic [15:0] pm_b;
    logic [3:0]  cnt_b;

    register_scoreboard #(.REG_ADDR_W(4), .NUM_REGS(16), .FWD_EN(1'b1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .freeze(freeze_a), .flush(flush_a),
        .id_valid(id_a.valid), .id_src_1(id_a.s1), .id_src_2(id_a.s2),
        .id_two_src(id_a.two), .id_wb_en(id_a.wb), .id_mem_read(id_a.mr),
        .id_dest(id_a.dest), .hazard_stall(hz_a), .wb_mem(wb_mem_a),
        .reg_dest_mem(rdm_a), .wb_wb(wb_wb_a), .reg_dest_wb(rdw_a),
        .pending_mask(pm_a), .stall_count(cnt_a)
    );

    register_scoreboard #(.REG_ADDR_W(4), .NUM_REGS(16), .FWD_EN(1'b0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .freeze(freeze_b), .flush(flush_b),
        .id_valid(id_b.valid), .id_src_1(id_b.s1), .id_src_2(id_b.s2),
        .id_two_src(id_b.two), .id_wb_en(id_b.wb), .id_mem_read(id_b.mr),
        .id_dest(id_b.dest), .hazard_stall(hz_b), .wb_mem(wb_mem_b),
        .reg_dest_mem(rdm_b), .wb_wb(wb_wb_b), .reg_dest_wb(rdw_b),
        .pending_mask(pm_b), .stall_count(cnt_b)
    );

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    logic adv_a = 1'b0;

    function automatic id_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                               input logic wb, input logic mr, input logic [3:0] dest);
        id_t t;
        t.valid = 1'b1; t.s1 = s1; t.s2 = s2; t.two = two;
        t.wb = wb; t.mr = mr; t.dest = dest;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- monitor ----------------
    // A WB tag is new only if the stages advanced on the preceding edge.
    always @(posedge clk) adv_a = !freeze_a && !rst;

    always @(negedge clk) begin
        if (adv_a && wb_wb_a) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_tag: got unexpected dest %0d, expected none", rdw_a);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (rdw_a !== e) begin
                    bad++;
                    $display("FAIL wb_tag: got dest %0d expected %0d", rdw_a, e);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] model_b;

        // reset state
        tick(); tick();
        chk("rst_wb_mem", {31'd0, wb_mem_a}, 32'd0);
        chk("rst_pm", {16'd0, pm_a}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
        rst = 1'b0;
        tick();

        // load-use: LDR r3 then ADD r5, r3, r4
        id_a = mk(4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3);
        settle();
        chk("lu_no_stall_ldr", {31'd0, hz_a}, 32'd0);
        tick(); exp_q.push_back(4'd3);
        id_a = mk(4'd3, 4'd4, 1'b1, 1'b1, 1'b0, 4'd5);
        settle();
        chk("lu_stall", {31'd0, hz_a}, 32'd1);
        chk("lu_pm_ex", {16'd0, pm_a}, 32'h0008);
        tick();
        settle();
        chk("lu_stall_clear", {31'd0, hz_a}, 32'd0);
        chk("lu_mem_wb", {31'd0, wb_mem_a}, 32'd1);
        chk("lu_mem_dest", {28'd0, rdm_a}, 32'd3);
        chk("lu_ex_bubble_pm", {16'd0, pm_a}, 32'h0008);
        chk("lu_cnt", {16'd0, cnt_a}, 32'd1);
        tick(); exp_q.push_back(4'd5);
        id_a = nop;
        tick(); tick(); tick();

        // ALU forward: ADD r2 then SUB r8, r2, r7 -- no stall with forwarding
        id_a = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2);
        settle();
        chk("alu_no_stall_1", {31'd0, hz_a}, 32'd0);
        tick(); exp_q.push_back(4'd2);
        id_a = mk(4'd2, 4'd7, 1'b1, 1'b1, 1'b0, 4'd8);
        settle();
        chk("alu_no_stall_2", {31'd0, hz_a}, 32'd0);
        tick(); exp_q.push_back(4'd8);
        id_a = nop;
        settle();
        chk("alu_mem_wb", {31'd0, wb_mem_a}, 32'd1);
        chk("alu_mem_dest", {28'd0, rdm_a}, 32'd2);
        chk("alu_pm", {16'd0, pm_a}, 32'h0104);
        tick();
        chk("alu_wb_wb", {31'd0, wb_wb_a}, 32'd1);
        chk("alu_wb_dest", {28'd0, rdw_a}, 32'd2);
        tick(); tick(); tick();

        // freeze with a load-use hazard pending
        id_a = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd6);
        tick(); exp_q.push_back(4'd6);
        id_a = mk(4'd6, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9);
        freeze_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("frz_stall", {31'd0, hz_a}, 32'd1);
            tick();
            chk("frz_pm", {16'd0, pm_a}, 32'h0040);
            chk("frz_mem", {31'd0, wb_mem_a}, 32'd0);
            chk("frz_cnt", {16'd0, cnt_a}, 32'd1);
        end
        freeze_a = 1'b0;
        tick();
        settle();
        chk("frz_rel_cnt", {16'd0, cnt_a}, 32'd2);
        chk("frz_rel_stall", {31'd0, hz_a}, 32'd0);
        chk("frz_rel_mem_dest", {28'd0, rdm_a}, 32'd6);
        tick(); exp_q.push_back(4'd9);
        id_a = nop;
        tick(); tick(); tick();

        // flush beats a load-use hazard
        id_a = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4);
        tick(); exp_q.push_back(4'd4);
        id_a = mk(4'd4, 4'd0, 1'b0, 1'b1, 1'b0, 4'd10);
        flush_a = 1'b1;
        settle();
        chk("fl_stall", {31'd0, hz_a}, 32'd0);
        tick();
        flush_a = 1'b0;
        id_a = nop;
        settle();
        chk("fl_cnt", {16'd0, cnt_a}, 32'd2);
        chk("fl_pm", {16'd0, pm_a}, 32'h0010);
        chk("fl_mem_dest", {28'd0, rdm_a}, 32'd4);
        tick(); tick(); tick();

        // freeze and flush together: nothing moves
        id_a = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd11);
        freeze_a = 1'b1;
        flush_a  = 1'b1;
        tick();
        chk("ff_pm", {16'd0, pm_a}, 32'd0);
        freeze_a = 1'b0;
        flush_a  = 1'b0;
        id_a = nop;
        tick();
        chk("ff_pm_after", {16'd0, pm_a}, 32'd0);
        chk("ff_cnt", {16'd0, cnt_a}, 32'd2);
        tick(); tick();
        chk("sb_drained", exp_q.size(), 32'd0);

        // FWD_EN=0: any producer in EX or MEM stalls
        id_b = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7);
        tick();
        id_b = mk(4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        chk("nf_ex_hit", {31'd0, hz_b}, 32'd1);
        id_b = nop;
        tick();
        id_b = mk(4'd1, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        chk("nf_mem_src2", {31'd0, hz_b}, 32'd1);
        id_b = mk(4'd1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        chk("nf_mem_no_two", {31'd0, hz_b}, 32'd0);
        id_b = nop;
        tick(); tick(); tick();
        chk("nf_cnt0", {28'd0, cnt_b}, 32'd0);

        // each round: producer then consumer stalls twice; counter saturates at 15
        model_b = 4'd0;
        for (int i = 0; i < 10; i++) begin
            id_b = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7);
            tick();
            id_b = mk(4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
            settle();
            chk("sat_stall_ex", {31'd0, hz_b}, 32'd1);
            tick();
            settle();
            chk("sat_stall_mem", {31'd0, hz_b}, 32'd1);
            tick();
            model_b = (model_b > 4'd13) ? 4'd15 : model_b + 4'd2;
            chk("sat_cnt", {28'd0, cnt_b}, {28'd0, model_b});
        end
        id_b = nop;
        tick(); tick(); tick();

        // asynchronous reset with all stages full
        id_a = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1);
        tick(); exp_q.push_back(4'd1);
        id_a = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd12);
        tick(); exp_q.push_back(4'd12);
        id_a = mk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd13);
        tick(); exp_q.push_back(4'd13);
        id_a = nop;
        chk("full_pm", {16'd0, pm_a}, 32'h3002);
        rst = 1'b1;
        exp_q.delete();
        settle();
        chk("arst_pm", {16'd0, pm_a}, 32'd0);
        chk("arst_wb_mem", {31'd0, wb_mem_a}, 32'd0);
        chk("arst_wb_wb", {31'd0, wb_wb_a}, 32'd0);
        chk("arst_dest_mem", {28'd0, rdm_a}, 32'd0);
        chk("arst_cnt", {16'd0, cnt_a}, 32'd0);
        chk("arst_cnt_b", {28'd0, cnt_b}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_pm", {16'd0, pm_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
